fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/rv_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 48 ++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared fetch-side constants and the fetch state encoding.
package rv_pkg;

  // addi x0,x0,0 -- presented to decode whenever no instruction is valid
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // First fetch address after reset
  localparam logic [31:0] RESET_PC = 32'h0100_0000;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order {pc, inst} buffer between the instruction memory and
// decode. Space is guaranteed by the requester, so push never checks for full.
module fetch_fifo (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_inst,
  input  logic        pop,
  input  logic        flush,
  output logic [1:0]  count,
  output logic [31:0] head_pc,
  output logic [31:0] head_inst
);

  logic [31:0] pc_mem   [2];
  logic [31:0] inst_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic        do_pop;

  assign do_pop = pop && (count != 2'd0);

  // Pointer and occupancy tracking; flush empties the buffer in one cycle
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push)   wr_ptr <= !wr_ptr;
      if (do_pop) rd_ptr <= !rd_ptr;
      count <= count + {1'b0, push} - {1'b0, do_pop};
    end
  end

  // Entry storage; contents are only meaningful while counted
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      pc_mem[wr_ptr]   <= push_pc;
      inst_mem[wr_ptr] <= push_inst;
    end
  end

  assign head_pc   = pc_mem[rd_ptr];
  assign head_inst = inst_mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, at most two
// requests in flight or buffered, and redirect handling that drops stale
// responses while draining them in DRAIN.
//
// state | meaning
// RUN   | issuing sequential fetches, enqueueing responses
// DRAIN | discarding responses for requests made before a redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC = rv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = rv_pkg::NOP_INST
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  rv_pkg::fetch_state_t state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] rsp_pc, rsp_pc_nxt;     // PC belonging to the next response
  logic [1:0]  outstanding, outstanding_nxt;
  logic [1:0]  drop_cnt, drop_nxt;
  logic [1:0]  remaining;              // outstanding left after this cycle's response
  logic [1:0]  fifo_count;
  logic [31:0] head_pc, head_inst;
  logic [2:0]  occupancy;
  logic        req_fire;
  logic        push;
  logic        pop;
  logic [31:0] target_pc;
  logic        unused_bits;

  assign unused_bits = ^redirect_pc[1:0];
  assign target_pc   = {redirect_pc[31:2], 2'b00};
  assign occupancy   = {1'b0, outstanding} + {1'b0, fifo_count};
  assign remaining   = outstanding - {1'b0, imem_rsp_valid};

  // Request only when every response is guaranteed a buffer slot
  assign imem_req_valid = !reset && (state == rv_pkg::RUN) && !redirect_valid &&
                          (occupancy < 3'd2);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_valid = (fifo_count != 2'd0);
  assign out_inst  = out_valid ? head_inst : NOP_INST;
  assign out_pc    = out_valid ? head_pc : 32'h0;
  assign pop       = out_valid && out_ready;

  fetch_fifo u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_pc   (rsp_pc),
    .push_inst (imem_rsp_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head_pc   (head_pc),
    .head_inst (head_inst)
  );

  // Next-state and datapath control; redirect wins over push, pop and accept
  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    rsp_pc_nxt      = rsp_pc;
    outstanding_nxt = outstanding;
    drop_nxt        = drop_cnt;
    push            = 1'b0;
    if (redirect_valid) begin
      fetch_pc_nxt    = target_pc;
      rsp_pc_nxt      = target_pc;
      outstanding_nxt = remaining;
      drop_nxt        = remaining;
      state_nxt       = (remaining != 2'd0) ? rv_pkg::DRAIN : rv_pkg::RUN;
    end else begin
      if (req_fire) fetch_pc_nxt = fetch_pc + 32'd4;
      outstanding_nxt = outstanding + {1'b0, req_fire} - {1'b0, imem_rsp_valid};
      case (state)
        rv_pkg::RUN: begin
          if (imem_rsp_valid) begin
            push       = 1'b1;
            rsp_pc_nxt = rsp_pc + 32'd4;
          end
        end
        rv_pkg::DRAIN: begin
          if (imem_rsp_valid) drop_nxt = drop_cnt - 2'd1;
          if (drop_nxt == 2'd0) state_nxt = rv_pkg::RUN;
        end
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= rv_pkg::RUN;
      fetch_pc    <= {RESET_PC[31:2], 2'b00};
      rsp_pc      <= {RESET_PC[31:2], 2'b00};
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      rsp_pc      <= rsp_pc_nxt;
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a cycle table for straight-line fetch and short
// back-pressure, then model-driven sequences for redirect, wrap and reset.
module tb_fetch_unit;

  localparam logic [31:0] P_RST = 32'h0100_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  // Cycle table: inputs and expected outputs, sampled before the rising edge
  typedef struct {
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        o_ready;
    logic        e_req_valid;
    logic [31:0] e_req_addr;
    logic        e_out_valid;
    logic [31:0] e_out_pc;
    logic [31:0] e_out_inst;
  } vec_t;

  function automatic vec_t mk(input logic rr, input logic rv, input logic [31:0] rd,
                              input logic ordy, input logic erv, input logic [31:0] era,
                              input logic eov, input logic [31:0] eop, input logic [31:0] eoi);
    vec_t v;
    v.req_ready = rr; v.rsp_valid = rv; v.rsp_data = rd; v.o_ready = ordy;
    v.e_req_valid = erv; v.e_req_addr = era;
    v.e_out_valid = eov; v.e_out_pc = eop; v.e_out_inst = eoi;
    return v;
  endfunction

  vec_t vecs[17];

  // Reactive memory model for the multi-cycle sequences
  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } pend_t;

  pend_t       q[$];
  int          cyc = 0;
  int          lat = 1;
  bit          rsp_hold = 1'b0;
  bit          mem_ready = 1'b1;
  logic [31:0] exp_pc;
  bit          s_acc, s_rsp, s_pop, s_req_valid, s_out_valid;
  logic [31:0] s_acc_addr;

  function automatic bit rsp_due();
    return !rsp_hold && (q.size() > 0) && (q[0].rdy <= cyc);
  endfunction

  task automatic cycle();
    pend_t p;
    imem_req_ready = mem_ready;
    imem_rsp_valid = rsp_due();
    imem_rsp_data  = 32'h0;
    if (imem_rsp_valid) imem_rsp_data = mem_word(q[0].addr);
    #2;
    s_req_valid = imem_req_valid;
    s_acc       = imem_req_valid && imem_req_ready;
    s_acc_addr  = imem_req_addr;
    s_rsp       = imem_rsp_valid;
    s_out_valid = out_valid;
    s_pop       = out_valid && out_ready;
    check("addr_align", {30'b0, imem_req_addr[1:0]}, 32'h0);
    if (reset) begin
      exp_pc = P_RST;
    end else begin
      if (s_pop) begin
        check("sb_pc", out_pc, exp_pc);
        check("sb_inst", out_inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clock);
    if (reset) begin
      q.delete();
    end else begin
      if (s_rsp) void'(q.pop_front());
      if (s_acc) begin
        p.addr = s_acc_addr;
        p.rdy  = cyc + lat;
        q.push_back(p);
      end
    end
    cyc++;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pops;
    bit          found;
    int          n_got;
    logic [31:0] got [2];

    vecs[0]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0100_0000, 1'b0, 32'h0,         NOP);
    vecs[1]  = mk(1'b1, 1'b1, 32'hA500_0000, 1'b1, 1'b1, 32'h0100_0004, 1'b0, 32'h0,         NOP);
    vecs[2]  = mk(1'b1, 1'b1, 32'hA500_0004, 1'b1, 1'b0, 32'h0100_0008, 1'b1, 32'h0100_0000, 32'hA500_0000);
    vecs[3]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0100_0008, 1'b1, 32'h0100_0004, 32'hA500_0004);
    vecs[4]  = mk(1'b1, 1'b1, 32'hA500_0008, 1'b1, 1'b1, 32'h0100_000C, 1'b0, 32'h0,         NOP);
    vecs[5]  = mk(1'b1, 1'b1, 32'hA500_000C, 1'b1, 1'b0, 32'h0100_0010, 1'b1, 32'h0100_0008, 32'hA500_0008);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0100_0010, 1'b1, 32'h0100_000C, 32'hA500_000C);
    vecs[7]  = mk(1'b1, 1'b1, 32'hA500_0010, 1'b0, 1'b1, 32'h0100_0014, 1'b0, 32'h0,         NOP);
    vecs[8]  = mk(1'b1, 1'b1, 32'hA500_0014, 1'b0, 1'b0, 32'h0100_0018, 1'b1, 32'h0100_0010, 32'hA500_0010);
    vecs[9]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0100_0018, 1'b1, 32'h0100_0010, 32'hA500_0010);
    vecs[10] = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0100_0018, 1'b1, 32'h0100_0010, 32'hA500_0010);
    vecs[11] = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0100_0018, 1'b1, 32'h0100_0014, 32'hA500_0014);
    vecs[12] = mk(1'b1, 1'b1, 32'hA500_0018, 1'b1, 1'b1, 32'h0100_001C, 1'b0, 32'h0,         NOP);
    vecs[13] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0100_0020, 1'b1, 32'h0100_0018, 32'hA500_0018);
    vecs[14] = mk(1'b0, 1'b1, 32'hA500_001C, 1'b1, 1'b1, 32'h0100_0020, 1'b0, 32'h0,         NOP);
    vecs[15] = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0100_0020, 1'b1, 32'h0100_001C, 32'hA500_001C);
    vecs[16] = mk(1'b1, 1'b1, 32'hA500_0020, 1'b1, 1'b1, 32'h0100_0024, 1'b0, 32'h0,         NOP);

    reset = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    repeat (3) @(negedge clock);

    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_req_addr", imem_req_addr, P_RST);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_inst", out_inst, NOP);
    check("rst_out_pc", out_pc, 32'h0);

    // Straight-line fetch and short back-pressure, cycle by cycle
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      imem_req_ready = vecs[i].req_ready;
      imem_rsp_valid = vecs[i].rsp_valid;
      imem_rsp_data  = vecs[i].rsp_data;
      out_ready      = vecs[i].o_ready;
      #2;
      check($sformatf("vec%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].e_req_valid});
      check($sformatf("vec%0d req_addr", i), imem_req_addr, vecs[i].e_req_addr);
      check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_out_valid});
      check($sformatf("vec%0d out_pc", i), out_pc, vecs[i].e_out_pc);
      check($sformatf("vec%0d out_inst", i), out_inst, vecs[i].e_out_inst);
      @(negedge clock);
    end

    reset = 1'b1;
    imem_rsp_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    q.delete();
    exp_pc = P_RST;
    reset = 1'b0;

    // Long back-pressure: buffer fills with the first two words, requests stop
    repeat (12) cycle();
    check("bp_out_valid", {31'b0, out_valid}, 32'h1);
    check("bp_head_pc", out_pc, P_RST);
    check("bp_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("bp_fifo_count", {30'b0, dut.u_fifo.count}, 32'h2);
    out_ready = 1'b1;
    pops = 0;
    repeat (24) begin
      cycle();
      if (s_pop) pops++;
    end
    check("bp_release_pops_ge12", {31'b0, (pops >= 12)}, 32'h1);

    // Redirect with two requests in flight
    rsp_hold = 1'b1;
    repeat (6) cycle();
    check("rd2_outstanding", {30'b0, dut.outstanding}, 32'h2);
    check("rd2_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rd2_out_valid", {31'b0, out_valid}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0100_0040;
    cycle();
    redirect_valid = 1'b0;
    check("rd2_in_drain", {31'b0, (dut.state == rv_pkg::DRAIN)}, 32'h1);
    rsp_hold = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cycle();
      check($sformatf("rd2_drop%0d rsp", k), {31'b0, s_rsp}, 32'h1);
      check($sformatf("rd2_drop%0d req_valid", k), {31'b0, s_req_valid}, 32'h0);
      check($sformatf("rd2_drop%0d out_valid", k), {31'b0, s_out_valid}, 32'h0);
    end
    check("rd2_back_run", {31'b0, (dut.state == rv_pkg::RUN)}, 32'h1);
    check("rd2_req_valid_after", {31'b0, imem_req_valid}, 32'h1);
    check("rd2_req_addr_after", imem_req_addr, 32'h0100_0040);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    check("rd2_out_seen", {31'b0, found}, 32'h1);
    check("rd2_first_pc", out_pc, 32'h0100_0040);

    // Redirect in the same cycle as a pop and a response
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid && rsp_due()) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    check("sim_setup_found", {31'b0, found}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0100_0200;
    cycle();
    redirect_valid = 1'b0;
    check("sim_pop_seen", {31'b0, s_pop}, 32'h1);
    check("sim_rsp_seen", {31'b0, s_rsp}, 32'h1);
    check("sim_out_valid_next", {31'b0, out_valid}, 32'h0);
    check("sim_req_addr_next", imem_req_addr, 32'h0100_0200);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    check("sim_out_seen", {31'b0, found}, 32'h1);
    check("sim_first_pc", out_pc, 32'h0100_0200);

    // Misaligned target and address wrap
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    cycle();
    redirect_valid = 1'b0;
    n_got = 0;
    got[0] = 32'h0;
    got[1] = 32'h0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (s_acc && n_got < 2) begin
        got[n_got] = s_acc_addr;
        n_got++;
      end
      if (n_got == 2) break;
    end
    check("wrap_fetches", n_got, 32'd2);
    check("wrap_first_addr", got[0], 32'hFFFF_FFFC);
    check("wrap_second_addr", got[1], 32'h0000_0000);
    repeat (6) cycle();

    // Reset mid-stream with work buffered and in flight; redirect alongside
    out_ready = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (dut.u_fifo.count != 2'd0) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    check("rst_setup_found", {31'b0, found}, 32'h1);
    rsp_hold = 1'b1;
    repeat (2) cycle();
    check("rst_setup_count", {30'b0, dut.u_fifo.count}, 32'h1);
    check("rst_setup_outstanding", {30'b0, dut.outstanding}, 32'h1);
    rsp_hold = 1'b0;
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0100_0300;
    cycle();
    redirect_valid = 1'b0;
    check("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("mid_rst_req_addr", imem_req_addr, P_RST);
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("mid_rst_out_inst", out_inst, NOP);
    check("mid_rst_out_pc", out_pc, 32'h0);
    check("mid_rst_outstanding", {30'b0, dut.outstanding}, 32'h0);
    check("mid_rst_fifo_count", {30'b0, dut.u_fifo.count}, 32'h0);
    reset = 1'b0;
    out_ready = 1'b1;
    cycle();
    check("post_rst_accept", {31'b0, s_acc}, 32'h1);
    check("post_rst_addr", s_acc_addr, P_RST);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    check("post_rst_out_seen", {31'b0, found}, 32'h1);
    check("post_rst_first_pc", out_pc, P_RST);
    repeat (8) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
